// File: rtl/tmf_mac_sequencer.sv
// Time-multiplexed MAC sequencer for one FIR filter: owns the delay line, coefficient
// bank and accumulator, and feeds an external combinational adder one tap per cycle.
module tmf_mac_sequencer #(
  parameter int unsigned NTAPS = 4,
  parameter int unsigned WI    = 2,
  parameter int unsigned WF    = 6,
  parameter int unsigned WIA   = 2,
  parameter int unsigned WFA   = 6
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     in_valid,
  input  logic [WI+WF-1:0]         in_sample,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [WI+WF-1:0]         coef_data,
  output logic [WIA+WFA-1:0]       add_in1,
  output logic [WIA+WFA-1:0]       add_in2,
  input  logic [WIA+WFA-1:0]       add_sum,
  output logic                     out_valid,
  output logic [WIA+WFA-1:0]       out_data,
  output logic                     prod_sat
);

  localparam int unsigned W  = WI + WF;
  localparam int unsigned WA = WIA + WFA;
  localparam int unsigned AW = $clog2(NTAPS);
  localparam int unsigned WP = 2 * W;
  localparam int unsigned SH = 2 * WF - WFA;
  localparam int unsigned WE = WP + WA;

  typedef enum logic [1:0] {IDLE, MAC, DONE} stateT;

  stateT             stateQ, stateD;
  logic [W-1:0]      xQ [NTAPS];
  logic [W-1:0]      cQ [NTAPS];
  logic [WA-1:0]     accQ;
  logic [AW-1:0]     tapQ;

  logic              acceptC, coefWrC, macC, lastTapC, satC;
  logic [W-1:0]      xSel, cSel;
  logic [WP-1:0]     xExt, cExt;
  logic signed [WP-1:0] prodFull, prodShr;
  logic [WE-1:0]     prodExt;
  logic [WE-WA:0]    prodHi;
  logic [WA-1:0]     prodC;

  // Product of the current tap: full product, floor-truncate, saturate to accumulator format
  always_comb begin
    xSel     = xQ[tapQ];
    cSel     = cQ[tapQ];
    xExt     = {{W{xSel[W-1]}}, xSel};
    cExt     = {{W{cSel[W-1]}}, cSel};
    prodFull = xExt * cExt;
    prodShr  = prodFull >>> SH;
    prodExt  = {{WA{prodShr[WP-1]}}, prodShr};
    prodHi   = prodExt[WE-1:WA-1];
    satC     = 1'b0;
    prodC    = prodExt[WA-1:0];
    if (prodHi != '0 && prodHi != '1) begin
      satC  = 1'b1;
      prodC = prodExt[WE-1] ? {1'b1, {(WA-1){1'b0}}} : {1'b0, {(WA-1){1'b1}}};
    end
  end

  // Next-state and control decode
  always_comb begin
    stateD   = stateQ;
    acceptC  = 1'b0;
    coefWrC  = 1'b0;
    macC     = 1'b0;
    lastTapC = (tapQ == AW'(NTAPS - 1));
    add_in1  = '0;
    add_in2  = '0;
    case (stateQ)
      IDLE: begin
        coefWrC = coef_we && (32'(coef_addr) < NTAPS);
        if (in_valid) begin
          acceptC = 1'b1;
          stateD  = MAC;
        end
      end
      MAC: begin
        macC    = 1'b1;
        add_in1 = prodC;
        add_in2 = accQ;
        if (lastTapC) stateD = DONE;
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        xQ[i] <= '0;
        cQ[i] <= '0;
      end
      accQ      <= '0;
      tapQ      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      prod_sat  <= 1'b0;
    end else begin
      if (coefWrC) cQ[coef_addr] <= coef_data;
      if (acceptC) begin
        for (int i = int'(NTAPS) - 1; i > 0; i--) xQ[i] <= xQ[i-1];
        xQ[0]    <= in_sample;
        accQ     <= '0;
        tapQ     <= '0;
        prod_sat <= 1'b0;
      end else if (macC) begin
        accQ <= add_sum;
        if (!lastTapC) tapQ <= tapQ + AW'(1);
        if (satC) prod_sat <= 1'b1;
      end
      in_ready  <= (stateD == IDLE);
      out_valid <= (stateQ == DONE);
      if (stateQ == DONE) out_data <= accQ;
    end
  end

endmodule

// File: tb/tb_tmf_mac_sequencer.sv
// Directed bench for tmf_mac_sequencer with a wrapping combinational adder model
// standing in for the team adder.
module tb_tmf_mac_sequencer;

  localparam int unsigned NTAPS = 4;

  logic       CLK, RST_N;
  logic       in_valid, in_ready, coef_we, out_valid, prod_sat;
  logic [7:0] in_sample, coef_data, add_in1, add_in2, add_sum, out_data;
  logic [1:0] coef_addr;

  int errCnt = 0;
  int chkCnt = 0;

  tmf_mac_sequencer #(.NTAPS(NTAPS), .WI(2), .WF(6), .WIA(2), .WFA(6)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
    .out_valid(out_valid), .out_data(out_data), .prod_sat(prod_sat)
  );

  // Adder model: plain two's-complement sum that wraps on overflow
  assign add_sum = add_in1 + add_in2;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic writeCoef(input logic [1:0] a, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  // Offer one sample (optionally with a c[0] write in the same cycle) and collect the result
  task automatic pushSample(input logic [7:0] s, input logic we, input logic [7:0] cd,
                            output logic [7:0] res, output logic [7:0] p0);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    checkVal("push_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sample = s;
    coef_we = we; coef_addr = 2'd0; coef_data = cd;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    p0 = add_in1;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 20);
    checkVal("latency", 32'(n), 32'(NTAPS + 1));
    res = out_data;
    tick();
    checkVal("pulse_width", 32'(out_valid), 32'd0);
  endtask

  logic [7:0] res, p0;
  logic [7:0] expA [4];
  logic [7:0] impC [4];
  int accepts[$];
  int n;

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_sample = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    #12;
    checkVal("rst_in_ready", 32'(in_ready), 32'd1);
    checkVal("rst_out_valid", 32'(out_valid), 32'd0);
    checkVal("rst_out_data", 32'(out_data), 32'd0);
    checkVal("rst_prod_sat", 32'(prod_sat), 32'd0);
    checkVal("rst_add_in1", 32'(add_in1), 32'd0);
    checkVal("rst_add_in2", 32'(add_in2), 32'd0);
    RST_N = 1'b1;
    tick();

    // All taps 0.5, constant 1.0 input builds up 0.5 per sample, last one wraps
    for (int i = 0; i < 4; i++) writeCoef(2'(i), 8'h20);
    expA[0] = 8'h20; expA[1] = 8'h40; expA[2] = 8'h60; expA[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      pushSample(8'h40, 1'b0, 8'h00, res, p0);
      checkVal($sformatf("ramp_out%0d", i), 32'(res), 32'(expA[i]));
      checkVal($sformatf("ramp_sat%0d", i), 32'(prod_sat), 32'd0);
    end
    checkVal("ramp_tap0", 32'(p0), 32'h20);

    // -2 * -2 = +4 saturates to the largest positive value
    writeCoef(2'd0, 8'h80);
    for (int i = 1; i < 4; i++) writeCoef(2'(i), 8'h00);
    pushSample(8'h80, 1'b0, 8'h00, res, p0);
    checkVal("sat_tap0", 32'(p0), 32'h7F);
    checkVal("sat_out", 32'(res), 32'h7F);
    checkVal("sat_flag", 32'(prod_sat), 32'd1);

    // Continuous in_valid; coef writes only while busy must not disturb c[0]
    in_valid = 1'b1; in_sample = 8'h80;
    for (int t = 0; t < 20; t++) begin
      coef_we = !in_ready; coef_addr = 2'd0; coef_data = 8'h00;
      if (in_ready) accepts.push_back(t);
      if (out_valid) checkVal("hold_out", 32'(out_data), 32'h7F);
      tick();
    end
    in_valid = 1'b0; coef_we = 1'b0;
    checkVal("hold_accepts", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++)
      checkVal($sformatf("hold_gap%0d", i), 32'(accepts[i] - accepts[i-1]), 32'd6);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checkVal("hold_last_out", 32'(out_data), 32'h7F);
    checkVal("hold_sat", 32'(prod_sat), 32'd1);
    tick();

    // Abort mid-computation with reset
    in_valid = 1'b1; in_sample = 8'h40;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checkVal("abort_busy", 32'(in_ready), 32'd0);
    checkVal("abort_acc_live", 32'(add_in2), 32'h80);
    RST_N = 1'b0;
    #1;
    checkVal("abort_out_data", 32'(out_data), 32'd0);
    checkVal("abort_out_valid", 32'(out_valid), 32'd0);
    checkVal("abort_in_ready", 32'(in_ready), 32'd1);
    checkVal("abort_add_in2", 32'(add_in2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("abort_no_valid", 32'(out_valid), 32'd0);
    end
    RST_N = 1'b1;
    tick();
    checkVal("abort_ready_after", 32'(in_ready), 32'd1);

    // Impulse response from an empty delay line
    impC[0] = 8'h10; impC[1] = 8'h20; impC[2] = 8'h30; impC[3] = 8'h40;
    for (int i = 0; i < 4; i++) writeCoef(2'(i), impC[i]);
    for (int i = 0; i < 4; i++) begin
      pushSample((i == 0) ? 8'h40 : 8'h00, 1'b0, 8'h00, res, p0);
      checkVal($sformatf("impulse%0d", i), 32'(res), 32'(impC[i]));
    end

    // -1/64 * 1/64 floors to -1/64 rather than rounding to zero
    writeCoef(2'd0, 8'h01);
    for (int i = 1; i < 4; i++) writeCoef(2'(i), 8'h00);
    pushSample(8'hFF, 1'b0, 8'h00, res, p0);
    checkVal("trunc_tap0", 32'(p0), 32'hFF);
    checkVal("trunc_out", 32'(res), 32'hFF);
    checkVal("trunc_sat", 32'(prod_sat), 32'd0);

    // Coefficient write and sample accept in the same cycle: new coefficient is used
    pushSample(8'h40, 1'b1, 8'h40, res, p0);
    checkVal("wr_accept_tap0", 32'(p0), 32'h40);
    checkVal("wr_accept_out", 32'(res), 32'h40);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/tmf_mac_sequencer.md
Name: tmf_mac_sequencer

Overview:
- Time-multiplexed MAC control stage for one FIR filter; it wraps the team's combinational fixed-point adder.
- Holds the sample delay line, the coefficient bank and the accumulator. Each tap cycle it forms one truncated, saturated product and drives the adder's in1 (product) and in2 (accumulator).
- It registers the adder's outAdd back into the accumulator.
- After NTAPS cycles it presents one filtered output sample downstream.

Parameters:
- NTAPS, 4, number of filter taps (2..16).
- WI, 2, integer bits of input sample and coefficients.
- WF, 6, fraction bits of input sample and coefficients.
- WIA, 2, integer bits of product, accumulator and adder output.
- WFA, 6, fraction bits of product, accumulator and adder output. Constraint: WFA <= 2*WF.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  new sample offered.
- in_sample  in  WI+WF  signed sample.
- in_ready  out  1  sequencer can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NTAPS)  coefficient index.
- coef_data  in  WI+WF  signed coefficient.
- add_in1  out  WIA+WFA  product to adder in1.
- add_in2  out  WIA+WFA  accumulator to adder in2.
- add_sum  in  WIA+WFA  adder outAdd.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  WIA+WFA  filtered sample.
- prod_sat  out  1  sticky: a product saturated in the current/last computation.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (RST_N=0, takes effect immediately):
  - State=IDLE; delay line, coefficients, accumulator, tap counter, out_data and prod_sat all 0.
  - out_valid=0, in_ready=1.
- FSM has three states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: x[0]<=in_sample and x[k]<=x[k-1] for k=1..NTAPS-1; acc<=0; k<=0; prod_sat<=0; go to MAC.
- MAC:
  - in_ready=0.
  - add_in1 = P(x[k], c[k]); add_in2 = acc.
  - Each edge: acc<=add_sum. If k==NTAPS-1, go to DONE; else k<=k+1.
- DONE (one cycle):
  - out_data<=acc, out_valid<=1 on the same edge; go to IDLE.
  - out_valid is high for exactly 1 cycle. out_data holds until the next result.
- Latency: sample accepted at edge 0 -> out_valid high during the cycle following edge NTAPS+1.
- Throughput: one sample per NTAPS+2 cycles.
- add_in1 and add_in2 are 0 outside MAC.
- Product P:
  - Full signed product is 2(WI+WF) bits with 2*WF fraction bits.
  - Drop the low 2*WF-WFA bits (truncate toward -inf).
  - Saturate the integer part to the signed WIA range: positive overflow -> 0111..1, negative -> 1000..0. Set prod_sat<=1 on any saturation.
- Accumulator: takes add_sum unmodified. Adder overflow is the adder's concern; no wrap check here.
- Coefficient bank:
  - c[coef_addr]<=coef_data on coef_we=1, in IDLE only; writes in MAC/DONE are ignored.
  - A write and a sample accept in the same IDLE cycle both take effect; MAC uses the new coefficient.
  - coef_addr >= NTAPS is ignored.
- in_valid outside IDLE is ignored. The sample is not queued; the upstream must hold it until in_ready.
- Reset asserted mid-MAC aborts the computation: no out_valid, delay line cleared.

Test Plan:
- Formats WI=WF=2/6, NTAPS=4. Load c[0..3]=0x20 (0.5); push 0x40 (1.0) -> out_data=0x20 after 6 cycles with a single out_valid pulse; push 0x40 again -> 0x40; two more pushes -> 0x60, 0x7F? No: 0x60 then 0x80 via adder wrap. Check both against the adder model; prod_sat stays 0.
- c[0]=0x80 (-2), others 0; push 0x80 -> product +4 saturates: add_in1=0x7F during tap 0, prod_sat=1, out_data=0x7F.
- Impulse response: c = 0x10,0x20,0x30,0x40; push 0x40 then three 0x00 -> outputs 0x10,0x20,0x30,0x40.
- Hold in_valid=1 continuously -> samples accepted only on in_ready cycles, exactly every 6 cycles; coef_we asserted during MAC leaves the bank unchanged.
- Drop RST_N during tap 2 -> outputs clear immediately, no out_valid; after release in_ready=1 and the next impulse test restarts with an empty delay line.
- Truncation: c[0]=0x01, sample 0xFF (-1/64) -> product -1/4096 floors to 0xFF (-1/64), not 0x00.
